// File: rtl/maxpool3x3_ctrl_if.sv
// Bus bundle for the 3x3 stride-2 max-pool sequencer: control, input-memory
// read port, output-memory write port and an FSM state tap.
interface maxpool3x3_ctrl_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    state_dbg;

    // Strobes have no ready: each memory takes one access per rd_en/wr_en
    // cycle, and rd_data is valid exactly one cycle after its rd_en.
    modport master (
        input  start, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, state_dbg
    );

    modport slave (
        output start, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, state_dbg
    );
endinterface

// File: rtl/maxpool3x3_ctrl.sv
// 3x3 stride-2 max-pool sequencer over NUM_CH square feature maps with one shared
// signed comparator. Optional fused ReLU: define MAXPOOL_RELU_EN.
module maxpool3x3_ctrl #(
    parameter int IN_DIM = 111,
    parameter int NUM_CH = 64,
    parameter int DW     = 16,
    parameter int AW     = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool3x3_ctrl_if.master    bus
);
    localparam int OUT_DIM  = (IN_DIM - 3) / 2 + 1;
    localparam int LAST_OFF = 2 * (OUT_DIM - 1);
    // Base-address jumps from the last window of a row / channel to the next one.
    localparam int ROW_STEP = 2 * IN_DIM - LAST_OFF;
    localparam int CH_STEP  = IN_DIM * IN_DIM - LAST_OFF * IN_DIM - LAST_OFF;
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OW       = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAST = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]        ch;
    logic [OW-1:0]        row_i, col_j;
    logic [1:0]           k, l;
    logic [AW-1:0]        win_base, next_base;
    logic [AW-1:0]        rd_addr_q, wr_addr_q, out_idx;
    logic                 rd_en_q, first_q;
    logic signed [DW-1:0] acc, din, cmp_base;
    logic                 last_win, last_tap;

    assign last_tap = (k == 2'd2) && (l == 2'd2);
    assign last_win = (ch == CW'(NUM_CH - 1)) && (row_i == OW'(OUT_DIM - 1)) &&
                      (col_j == OW'(OUT_DIM - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.start) state_nx = S_RD;
            S_RD:   if (last_tap) state_nx = S_LAST;
            S_LAST: state_nx = S_WR;
            S_WR:   state_nx = last_win ? S_DONE : S_RD;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != S_IDLE);
        bus.done  = (state == S_DONE);
        bus.rd_en = (state == S_RD);
        bus.wr_en = (state == S_WR);
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = acc;
    assign bus.state_dbg = state;

    always_comb begin
        next_base = win_base + AW'(2);
        if (col_j == OW'(OUT_DIM - 1)) begin
            if (row_i == OW'(OUT_DIM - 1)) next_base = win_base + AW'(CH_STEP);
            else                           next_base = win_base + AW'(ROW_STEP);
        end
    end

    // First sample of a window replaces acc via cmp_base instead of competing with it.
    assign din = $signed(bus.rd_data);
    always_comb begin
        cmp_base = acc;
        if (first_q) begin
`ifdef MAXPOOL_RELU_EN
            cmp_base = '0;
`else
            cmp_base = din;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch        <= '0;
            row_i     <= '0;
            col_j     <= '0;
            k         <= '0;
            l         <= '0;
            win_base  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            out_idx   <= '0;
            rd_en_q   <= 1'b0;
            first_q   <= 1'b0;
            acc       <= '0;
        end else begin
            rd_en_q <= (state == S_RD);
            first_q <= (state == S_RD) && (k == 2'd0) && (l == 2'd0);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ch        <= '0;
                        row_i     <= '0;
                        col_j     <= '0;
                        k         <= '0;
                        l         <= '0;
                        win_base  <= '0;
                        rd_addr_q <= '0;
                        out_idx   <= '0;
                    end
                end
                S_RD: begin
                    if (l == 2'd2) begin
                        l <= 2'd0;
                        k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
                        if (k != 2'd2) rd_addr_q <= rd_addr_q + AW'(IN_DIM - 2);
                    end else begin
                        l         <= l + 2'd1;
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                S_LAST: wr_addr_q <= out_idx;
                S_WR: begin
                    out_idx <= out_idx + AW'(1);
                    if (!last_win) begin
                        win_base  <= next_base;
                        rd_addr_q <= next_base;
                        if (col_j == OW'(OUT_DIM - 1)) begin
                            col_j <= '0;
                            if (row_i == OW'(OUT_DIM - 1)) begin
                                row_i <= '0;
                                ch    <= ch + CW'(1);
                            end else begin
                                row_i <= row_i + OW'(1);
                            end
                        end else begin
                            col_j <= col_j + OW'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (rd_en_q) acc <= (din > cmp_base) ? din : cmp_base;
        end
    end
endmodule
